// File: rtl/midi_msg_receiver_if.sv
// Message-side bus of the MIDI receiver: head-of-FIFO message, pop strobe and status flags.
// The receiver uses the master modport, the consumer the slave modport.
interface midi_msg_receiver_if;
    logic        rd_en;
    logic [23:0] msg_out;
    logic [1:0]  msg_len;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        frame_err;

    modport master (
        input  rd_en,
        output msg_out, msg_len, empty, full, overflow, frame_err
    );

    modport slave (
        output rd_en,
        input  msg_out, msg_len, empty, full, overflow, frame_err
    );
endinterface

// File: rtl/midi_msg_receiver.sv
// MIDI serial receiver and message assembler with running status, real-time
// interleaving, per-channel filtering and a first-word-fall-through message FIFO.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | half-bit wait, then confirm the start bit
// DATA  | eight LSB-first samples, one per bit period
// STOP  | sample the stop bit
// BRK   | stop bit was low; wait for the line to return high
module midi_msg_receiver #(
    parameter int          CLKS_PER_BIT = 1600,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                din,
    midi_msg_receiver_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] RELOAD_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] RELOAD_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} rx_state_t;

    rx_state_t     state_q, state_d;
    logic          din_s1, din_s2, din_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          byte_vld_q, ferr_q;
    logic          fall, tick;
    logic          load_half, load_full, dec, shift_en, byte_ok, byte_bad;

    assign fall = din_d & ~din_s2;
    assign tick = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            din_s1 <= 1'b1;
            din_s2 <= 1'b1;
            din_d  <= 1'b1;
        end else begin
            din_s1 <= din;
            din_s2 <= din_s1;
            din_d  <= din_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (fall) state_d = START;
            START: if (tick) state_d = din_s2 ? IDLE : DATA;
            DATA:  if (tick && bit_idx_q == 3'd7) state_d = STOP;
            STOP:  if (tick) state_d = din_s2 ? IDLE : BRK;
            BRK:   if (din_s2) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_half = 1'b0;
        load_full = 1'b0;
        dec       = 1'b0;
        shift_en  = 1'b0;
        byte_ok   = 1'b0;
        byte_bad  = 1'b0;
        case (state_q)
            IDLE:  load_half = fall;
            START: begin load_full = tick; dec = ~tick; end
            DATA:  begin load_full = tick; shift_en = tick; dec = ~tick; end
            STOP:  begin byte_ok = tick & din_s2; byte_bad = tick & ~din_s2; dec = ~tick; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            byte_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            if (load_half)      cnt_q <= RELOAD_HALF;
            else if (load_full) cnt_q <= RELOAD_FULL;
            else if (dec)       cnt_q <= cnt_q - 1'b1;
            if (load_half)      bit_idx_q <= '0;
            else if (shift_en)  bit_idx_q <= bit_idx_q + 1'b1;
            if (shift_en)       shift_q <= {din_s2, shift_q[7:1]};
            byte_vld_q <= byte_ok;
            ferr_q     <= byte_bad;
        end
    end

    // cur_q doubles as running status: need_q stays armed after a channel message completes.
    logic [7:0]  cur_q, d1_q;
    logic [1:0]  need_q;
    logic        idx_q;
    logic        push_q;
    logic [23:0] push_msg_q;
    logic [1:0]  push_len_q;
    logic        chan_ok;

    assign chan_ok = (cur_q[7:4] == 4'hF) || CHANNEL_MASK[cur_q[3:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q      <= '0;
            d1_q       <= '0;
            need_q     <= '0;
            idx_q      <= 1'b0;
            push_q     <= 1'b0;
            push_msg_q <= '0;
            push_len_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (byte_vld_q) begin
                if (shift_q[7:3] == 5'b11111) begin
                    push_q     <= 1'b1;
                    push_msg_q <= {shift_q, 16'h0000};
                    push_len_q <= 2'd1;
                end else if (shift_q[7]) begin
                    idx_q <= 1'b0;
                    casez (shift_q)
                        8'b10??_????, 8'b1110_????: begin cur_q <= shift_q; need_q <= 2'd2; end
                        8'b110?_????:               begin cur_q <= shift_q; need_q <= 2'd1; end
                        8'hF1, 8'hF3:               begin cur_q <= shift_q; need_q <= 2'd1; end
                        8'hF2:                      begin cur_q <= shift_q; need_q <= 2'd2; end
                        8'hF6: begin
                            need_q     <= 2'd0;
                            push_q     <= 1'b1;
                            push_msg_q <= {shift_q, 16'h0000};
                            push_len_q <= 2'd1;
                        end
                        default: need_q <= 2'd0;
                    endcase
                end else if (need_q != 2'd0) begin
                    if (need_q == 2'd1 || idx_q) begin
                        push_q     <= chan_ok;
                        push_msg_q <= (need_q == 2'd1) ? {cur_q, shift_q, 8'h00} : {cur_q, d1_q, shift_q};
                        push_len_q <= (need_q == 2'd1) ? 2'd2 : 2'd3;
                        idx_q      <= 1'b0;
                        if (cur_q[7:4] == 4'hF) need_q <= 2'd0;
                    end else begin
                        d1_q  <= shift_q;
                        idx_q <= 1'b1;
                    end
                end
            end
        end
    end

    logic [25:0] mem [FIFO_DEPTH];
    logic [AW:0] wp_q, rp_q;
    logic        empty_w, full_w, do_pop, do_push, ovf_q;
    logic [25:0] head;

    assign empty_w = (wp_q == rp_q);
    assign full_w  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign do_pop  = bus.rd_en && !empty_w;
    assign do_push = push_q && (!full_w || do_pop);
    assign head    = mem[rp_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
            if (push_q && !do_push) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp_q[AW-1:0]] <= {push_len_q, push_msg_q};
    end

    assign bus.msg_out   = empty_w ? 24'h0 : head[23:0];
    assign bus.msg_len   = empty_w ? 2'd0  : head[25:24];
    assign bus.empty     = empty_w;
    assign bus.full      = full_w;
    assign bus.overflow  = ovf_q;
    assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_midi_msg_receiver.sv
// Directed bench for midi_msg_receiver: serial stimulus with expected messages queued
// as bytes are sent, then popped and compared while draining the FIFO.
module tb_midi_msg_receiver;
    localparam int          C     = 16;
    localparam int          H     = C / 2;
    localparam int          DEPTH = 16;
    localparam logic [15:0] MASK  = 16'hFFDF;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic din   = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   start_cyc = 0;
    int   fall_cyc = -1;
    int   ferr_cnt = 0;
    logic prev_empty = 1'b1;
    logic [25:0] exp_q [$];

    midi_msg_receiver_if bus ();

    midi_msg_receiver #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .CHANNEL_MASK(MASK)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (prev_empty && !bus.empty) fall_cyc = cyc;
        prev_empty = bus.empty;
        if (bus.frame_err) ferr_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL timeout: run did not complete within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        logic [7:0] v;
        v = b;
        din = 1'b0;
        start_cyc = cyc;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            din = v[i];
            tick(C);
        end
        din = stop;
        tick(C);
        din = 1'b1;
        if (!stop) tick(C);
    endtask

    task automatic expect_msg(input logic [1:0] len, input logic [23:0] msg);
        exp_q.push_back({len, msg});
    endtask

    task automatic drain(input string tag);
        logic [25:0] e;
        int guard;
        guard = 0;
        while (!bus.empty && guard < 40) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 26'h3FFFFFF;
            chk({tag, "_msg"}, {8'h00, bus.msg_out}, {8'h00, e[23:0]});
            chk({tag, "_len"}, {30'h0, bus.msg_len}, {30'h0, e[25:24]});
            bus.rd_en = 1'b1;
            tick(1);
            bus.rd_en = 1'b0;
            guard++;
        end
        chk({tag, "_missing"}, exp_q.size(), 0);
        chk({tag, "_empty"}, {31'h0, bus.empty}, 32'd1);
        exp_q.delete();
    endtask

    initial begin
        bus.rd_en = 1'b0;
        tick(3);
        chk("rst_empty", {31'h0, bus.empty}, 32'd1);
        chk("rst_full", {31'h0, bus.full}, 32'd0);
        chk("rst_overflow", {31'h0, bus.overflow}, 32'd0);
        chk("rst_frame_err", {31'h0, bus.frame_err}, 32'd0);
        chk("rst_msg_out", {8'h0, bus.msg_out}, 32'd0);
        chk("rst_msg_len", {30'h0, bus.msg_len}, 32'd0);
        reset = 1'b0;
        tick(4);

        // Single note-on and push latency from the last start edge.
        send_byte(8'h90); send_byte(8'h3C);
        expect_msg(2'd3, 24'h903C64);
        send_byte(8'h64);
        tick(2);
        chk("t1_latency", fall_cyc - start_cyc, H + 5 + 9 * C);
        drain("t1");

        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'h40); send_byte(8'h00);
        expect_msg(2'd3, 24'h903C64);
        expect_msg(2'd3, 24'h904000);
        tick(2);
        drain("t2_running");

        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
        expect_msg(2'd1, 24'hF80000);
        expect_msg(2'd3, 24'h903C64);
        tick(2);
        drain("t3_realtime");

        send_byte(8'hC5); send_byte(8'h07);
        tick(2);
        drain("t4_filtered");
        send_byte(8'hC3); send_byte(8'h07);
        expect_msg(2'd2, 24'hC30700);
        tick(2);
        drain("t4_pass");

        ferr_cnt = 0;
        send_byte(8'h3C, 1'b0);
        tick(C);
        chk("t5_frame_err_cycles", ferr_cnt, 1);
        send_byte(8'h3C);
        expect_msg(2'd2, 24'hC33C00);
        din = 1'b0;
        tick(4);
        din = 1'b1;
        tick(3 * C);
        drain("t5_err_glitch");

        send_byte(8'h90);
        for (int i = 0; i < DEPTH + 1; i++) begin
            send_byte(8'h10 + 8'(i));
            send_byte(8'h40);
            if (i < DEPTH) expect_msg(2'd3, {8'h90, 8'h10 + 8'(i), 8'h40});
        end
        tick(2);
        chk("t6_full", {31'h0, bus.full}, 32'd1);
        chk("t6_overflow", {31'h0, bus.overflow}, 32'd1);
        drain("t6_order");
        chk("t6_overflow_sticky", {31'h0, bus.overflow}, 32'd1);

        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        din = 1'b0;
        tick(5 * C);
        reset = 1'b1;
        tick(2);
        din = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("t6r_empty", {31'h0, bus.empty}, 32'd1);
        chk("t6r_overflow", {31'h0, bus.overflow}, 32'd0);
        chk("t6r_full", {31'h0, bus.full}, 32'd0);
        chk("t6r_msg_out", {8'h0, bus.msg_out}, 32'd0);
        tick(2 * C);
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        expect_msg(2'd3, 24'h903C64);
        tick(2);
        drain("t6r_clean");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/midi_msg_receiver.md
Name: midi_msg_receiver

Overview:
Parametrised successor to the byte-level MIDI receiver behind midi_top. It deserialises the MIDI serial line with a configurable bit period and assembles raw bytes into complete MIDI messages. It handles running status, real-time interleaving and per-channel filtering, then buffers whole messages in a first-word-fall-through FIFO. It sits between the MIDI input pin and the synth voice allocator, which reads one full message per rd_en.

Parameters:
CLKS_PER_BIT, 1600, clk cycles per MIDI bit (50 MHz / 31250 baud); must be >= 8.
FIFO_DEPTH, 16, message FIFO entries; power of two, >= 2.
CHANNEL_MASK, 16'hFFFF, bit n = 1 accepts channel-voice messages on channel n (status low nibble).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
din  in  1  asynchronous MIDI serial input, idle high
rd_en  in  1  pop head message; ignored when empty=1
msg_out  out  24  head message: [23:16] status, [15:8] data1, [7:0] data2; absent bytes are 0
msg_len  out  2  byte count of head message, 1..3
empty  out  1  FIFO empty
full  out  1  FIFO holds FIFO_DEPTH messages
overflow  out  1  sticky: a complete message was dropped because the FIFO was full
frame_err  out  1  one-cycle pulse on a stop-bit error

Behaviour:
- Reset, sampled at the clk edge, returns all state to its initial value from any point, including mid-byte:
  - outputs: empty=1, full=0, overflow=0, frame_err=0, msg_out=0, msg_len=0
  - FIFO pointers cleared; running status cleared; partial message discarded; RX FSM goes to IDLE.
- din passes through a 2-flop synchroniser before any use.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a falling edge on synchronised din moves to START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. Low goes to DATA; high is a glitch and returns to IDLE with no output.
  - DATA: 8 samples at CLKS_PER_BIT intervals, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. High delivers the byte to the parser. Low pulses frame_err for 1 cycle, discards the byte, then waits for din high before IDLE.
- Parser (registered state: running status, expected data count, data index, data1):
  - 0x80-0xBF, 0xE0-0xEF: set running status, expect 2 data bytes.
  - 0xC0-0xDF: set running status, expect 1 data byte.
  - 0xF1, 0xF3: expect 1 data byte. 0xF2: expect 2. All three clear running status.
  - 0xF6: push a 1-byte message immediately; clears running status.
  - 0xF0 (SysEx start), 0xF7, 0xF4, 0xF5: clear running status; following data bytes are discarded until the next status byte.
  - 0xF8-0xFF (real-time): push a 1-byte message immediately. Running status and any partial message are untouched.
  - Data byte (bit7=0):
    - with no running status: dropped;
    - otherwise: stored; when the expected count is reached the message is pushed and the index resets.
    - Running status persists, so the next data byte starts a new message with the same status.
  - A status byte arriving mid-message abandons the partial message.
  - Channel filter: a completed channel-voice message whose channel bit in CHANNEL_MASK is 0 is not pushed; running status is still tracked.
- Latency and FIFO:
  - A push occurs 1 cycle after the final byte's stop-bit sample; empty deasserts on the following edge.
  - Push when full: message dropped, overflow set until reset.
  - Simultaneous push and pop: both take effect. When full, the pop frees the slot, so no drop occurs and full stays 1.
  - Simultaneous push and pop when empty: the pop is ignored and the push takes effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - msg_out/msg_len show the head entry while empty=0, and 0 while empty=1.

Test Plan:
1. Defaults. Serial 90 3C 64 at 32000 ns/bit -> one message 0x903C64, len 3. empty falls 2 cycles after the third stop-bit sample.
2. Running status. Bytes 90 3C 64 40 00 -> 0x903C64 (len 3) then 0x904000 (len 3); no other entries.
3. Real-time interleave. 90 3C F8 64 -> 0xF80000 (len 1) first, then 0x903C64 (len 3).
4. Channel filter. CHANNEL_MASK=16'hFFDF: C5 07 -> no message. Then C3 07 -> 0xC30700 (len 2).
5. Errors and glitch:
   - byte with stop bit low -> frame_err high exactly 1 cycle, no message; next valid byte decoded correctly;
   - 10 µs low pulse on din -> no output.
6. Overflow and reset:
   - 17 Note-On messages with no reads -> full=1, overflow=1; 16 reads return the first 16 in order.
   - reset asserted mid-byte -> empty=1, overflow=0; a subsequent clean message is decoded.
